jam_cost_rom_arbiter: RTL

- Shares the single 8x8 cost ROM port (W/J address, 7-bit Cost, 1-cycle read latency) between NREQ job-assignment engines.
- Each cycle, one requester is granted the ROM using round-robin order.
- Drives the granted address to the ROM and returns the read data one cycle later, tagged to the owner.
- Sits between the JAM search engines and the cost ROM in the multi-engine JAM build.

---
 rtl/jam_cost_rom_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/jam_cost_rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency 8x8 cost ROM between NREQ JAM engines.
// Define JAM_ARB_LOCK_EN to add the ARB/LOCKED burst-hold FSM (up to MAX_BURST grants).
module jam_cost_rom_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_w,
  input  logic [3*NREQ-1:0] req_j,
  input  logic [NREQ-1:0]   lock,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [6:0]        rdata,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [6:0]        Cost
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_rr_ptr;
  logic [NREQ-1:0] r_rvalid;
  logic [2:0]      r_last_w;
  logic [2:0]      r_last_j;

  logic [NREQ-1:0] w_rr_gnt;
  logic [PW-1:0]   w_rr_idx;
  logic            w_rr_any;
  logic [PW-1:0]   w_scan;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_gnt_idx;
  logic            w_gnt_any;
  logic [2:0]      w_sel_w;
  logic [2:0]      w_sel_j;

  // Scan from r_rr_ptr upward with wrap; first requester found wins.
  always_comb begin : rr_scan
    w_rr_gnt = '0;
    w_rr_idx = '0;
    w_rr_any = 1'b0;
    w_scan   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_scan = PW'((32'(r_rr_ptr) + i) % NREQ);
      if (!w_rr_any && req[w_scan]) begin
        w_rr_any         = 1'b1;
        w_rr_idx         = w_scan;
        w_rr_gnt[w_scan] = 1'b1;
      end
    end
  end

`ifdef JAM_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_owner;
  logic [CW-1:0] r_burst_cnt;
  logic          w_hold;
  logic          w_lock_start;

  // Owner keeps the port only while it still requests, still locks and has burst budget left.
  assign w_hold = (r_state == LOCKED) && req[r_owner] && lock[r_owner] &&
                  (r_burst_cnt != CW'(MAX_BURST));

  always_ff @(posedge CLK) begin : state_reg
    if (!RST) begin
      r_state     <= ARB;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold) begin
        if (r_burst_cnt != CW'(MAX_BURST)) r_burst_cnt <= r_burst_cnt + 1'b1;
      end else if (w_lock_start) begin
        r_owner     <= w_gnt_idx;
        r_burst_cnt <= CW'(1);
      end
    end
  end

  always_comb begin : next_state
    w_lock_start = !w_hold && w_gnt_any && lock[w_gnt_idx];
    w_state_nxt  = ARB;
    if (w_hold || w_lock_start) w_state_nxt = LOCKED;
  end

  always_comb begin : out_comb
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (RST) begin
      if (w_hold) begin
        w_gnt[r_owner] = 1'b1;
        w_gnt_idx      = r_owner;
        w_gnt_any      = 1'b1;
      end else begin
        w_gnt     = w_rr_gnt;
        w_gnt_idx = w_rr_idx;
        w_gnt_any = w_rr_any;
      end
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = (^lock) ^ (MAX_BURST == 0);

  always_comb begin : out_comb
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    if (RST) begin
      w_gnt     = w_rr_gnt;
      w_gnt_idx = w_rr_idx;
      w_gnt_any = w_rr_any;
    end
  end
`endif

  always_comb begin : addr_mux
    w_sel_w = r_last_w;
    w_sel_j = r_last_j;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_w = req_w[3*k +: 3];
        w_sel_j = req_j[3*k +: 3];
      end
    end
  end

  always_ff @(posedge CLK) begin : datapath
    if (!RST) begin
      r_rr_ptr <= '0;
      r_rvalid <= '0;
      r_last_w <= '0;
      r_last_j <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt_any) begin
        r_rr_ptr <= PW'((32'(w_gnt_idx) + 1) % NREQ);
        r_last_w <= w_sel_w;
        r_last_j <= w_sel_j;
      end
    end
  end

  assign gnt    = w_gnt;
  assign rvalid = r_rvalid;
  assign rdata  = Cost;
  assign W      = w_sel_w;
  assign J      = w_sel_j;

endmodule
